// File: rtl/tail_light_sequencer.sv
// Thunderbird-style turn/hazard sequencer producing the raw 3-lamp-per-side
// pattern for the downstream tail-light dimmer; steps advance on a prescaled tick.
module tail_light_sequencer #(
    parameter int STEP_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
    output logic [2:0] Lcba,
    output logic [2:0] Rabc,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        L1,
        L2,
        L3,
        R1,
        R2,
        R3,
        LR3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             haz_req;

    assign tick    = (cnt == LAST);
    assign haz_req = hazard | (left & right);

    // Lamp pattern {Lcba, Rabc} shown while in a given state.
    function automatic logic [5:0] lamp_pattern(input state_t s);
        case (s)
            L1:      lamp_pattern = 6'b001_000;
            L2:      lamp_pattern = 6'b011_000;
            L3:      lamp_pattern = 6'b111_000;
            R1:      lamp_pattern = 6'b000_100;
            R2:      lamp_pattern = 6'b000_110;
            R3:      lamp_pattern = 6'b000_111;
            LR3:     lamp_pattern = 6'b111_111;
            default: lamp_pattern = 6'b000_000;
        endcase
    endfunction

    // Hazard overrides a running turn sequence, but a turn never jumps straight
    // into the opposite turn: it always returns to IDLE first.
    always_comb begin
        state_nx = state;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (haz_req)    state_nx = LR3;
                    else if (left)  state_nx = L1;
                    else if (right) state_nx = R1;
                    else            state_nx = IDLE;
                end
                L1:      state_nx = haz_req ? LR3 : L2;
                L2:      state_nx = haz_req ? LR3 : L3;
                L3:      state_nx = haz_req ? LR3 : IDLE;
                R1:      state_nx = haz_req ? LR3 : R2;
                R2:      state_nx = haz_req ? LR3 : R3;
                R3:      state_nx = haz_req ? LR3 : IDLE;
                LR3:     state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Outputs decode the next state so lamps change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            Lcba  <= 3'b000;
            Rabc  <= 3'b000;
            busy  <= 1'b0;
        end else begin
            cnt          <= tick ? '0 : cnt + CNT_W'(1);
            state        <= state_nx;
            {Lcba, Rabc} <= lamp_pattern(state_nx);
            busy         <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Randomized bench for tail_light_sequencer: two instances (STEP_DIV=1 and 4)
// share stimulus and are compared each cycle against a step-count reference model.
module tb_tail_light_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       left;
    logic       right;
    logic       hazard;
    logic [2:0] lcba1, rabc1, lcba4, rabc4;
    logic       busy1, busy4;

    int errors = 0;
    int checks = 0;

    // Model state per instance: kind 0=idle 1=left 2=right 3=hazard; step 1..3.
    int divs [2] = '{1, 4};
    int phase[2];
    int kind [2];
    int step [2];

    always #5 clk = ~clk;

    tail_light_sequencer #(.STEP_DIV(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .Lcba(lcba1), .Rabc(rabc1), .busy(busy1)
    );

    tail_light_sequencer #(.STEP_DIV(4), .CNT_W(16)) dut4 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .Lcba(lcba4), .Rabc(rabc4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Advance one instance's model by one clock edge with the sampled inputs.
    task automatic model_step(input int d);
        bit tk, hz;
        if (reset) begin
            phase[d] = 0;
            kind[d]  = 0;
            step[d]  = 0;
        end else begin
            tk = (phase[d] == divs[d] - 1);
            phase[d] = tk ? 0 : phase[d] + 1;
            if (tk) begin
                hz = hazard | (left & right);
                if (kind[d] == 3) begin
                    kind[d] = 0;
                end else if (hz) begin
                    kind[d] = 3;
                end else if (kind[d] == 0) begin
                    if (left)       begin kind[d] = 1; step[d] = 1; end
                    else if (right) begin kind[d] = 2; step[d] = 1; end
                end else if (step[d] == 3) begin
                    kind[d] = 0;
                end else begin
                    step[d] = step[d] + 1;
                end
            end
        end
    endtask

    function automatic logic [2:0] exp_left(input int d);
        if (kind[d] == 3) return 3'b111;
        if (kind[d] == 1) return 3'((1 << step[d]) - 1);
        return 3'b000;
    endfunction

    function automatic logic [2:0] exp_right(input int d);
        if (kind[d] == 3) return 3'b111;
        if (kind[d] == 2) return 3'(8 - (8 >> step[d]));
        return 3'b000;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("div1_Lcba", {5'b0, lcba1}, {5'b0, exp_left(0)});
        check("div1_Rabc", {5'b0, rabc1}, {5'b0, exp_right(0)});
        check("div1_busy", {7'b0, busy1}, {7'b0, kind[0] != 0});
        check("div4_Lcba", {5'b0, lcba4}, {5'b0, exp_left(1)});
        check("div4_Rabc", {5'b0, rabc4}, {5'b0, exp_right(1)});
        check("div4_busy", {7'b0, busy4}, {7'b0, kind[1] != 0});
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit l, input bit rt, input bit h, input int n);
        reset = r; left = l; right = rt; hazard = h;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0;
        for (int d = 0; d < 2; d++) begin
            phase[d] = 0; kind[d] = 0; step[d] = 0;
        end
        @(negedge clk);

        drive(1, 1, 0, 0, 10);     // reset dominates a held left request
        drive(0, 1, 0, 0, 20);     // full left sequences, first tick on 4th edge
        drive(1, 0, 0, 0, 2);
        drive(0, 0, 1, 0, 1);      // single-cycle right pulse
        drive(0, 0, 0, 0, 10);
        drive(1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 2);
        drive(0, 1, 0, 1, 8);      // hazard during a left sequence
        drive(0, 0, 0, 0, 6);
        drive(0, 1, 1, 0, 12);     // left+right treated as hazard
        drive(0, 0, 0, 0, 4);
        drive(0, 0, 1, 0, 9);
        drive(1, 0, 1, 0, 1);      // reset mid right sequence
        drive(0, 0, 1, 0, 10);
        drive(0, 1, 0, 0, 6);      // left then switch to right mid-sequence
        drive(0, 0, 1, 0, 20);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                left   = ($urandom_range(0, 2) == 0);
                right  = ($urandom_range(0, 2) == 0);
                hazard = ($urandom_range(0, 5) == 0);
            end
            reset = ($urandom_range(0, 149) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tail_light_sequencer.md
Name: tail_light_sequencer

Overview:
- Thunderbird-style turn/hazard sequencer that produces the raw lamp pattern for the tail-light dimmer stage directly downstream.
- Converts left, right and hazard requests into a stepped 3-lamp-per-side pattern: Lcba = {Lc,Lb,La}, Rabc = {Ra,Rb,Rc}.
- Steps advance on an internal prescaled tick.
- Outputs are registered and connect straight to the dimmer's Lcba/Rabc inputs.

Parameters:
STEP_DIV, 4, number of clk cycles per sequence step; legal range 1..65535 (1 = step every cycle)
CNT_W, 16, width of prescale counter; must satisfy 2^CNT_W >= STEP_DIV

Ports:
clk  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
left  input  1  left-turn request, level
right  input  1  right-turn request, level
hazard  input  1  hazard request, level
Lcba  output  3  left lamps {Lc,Lb,La}, La innermost; registered
Rabc  output  3  right lamps {Ra,Rb,Rc}, Ra innermost; registered
busy  output  1  high whenever state != IDLE; registered

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All flops update only on the clk rising edge.
- Reset:
  - On a clk edge with reset=1: state=IDLE, prescale counter=0, Lcba=3'b000, Rabc=3'b000, busy=0.
  - Applies identically mid-sequence; no partial pattern survives.
- Prescaler:
  - Counter counts 0..STEP_DIV-1 and wraps to 0.
  - tick=1 in the cycle where counter==STEP_DIV-1.
  - Counter free-runs; it is not restarted by requests.
- State transitions occur only on cycles with tick=1. With tick=0, state holds.
- Request decode is sampled at the tick:
  - haz_req = hazard | (left & right).
  - Priority: haz_req > left > right.
- States and output patterns (Lcba/Rabc):
  - IDLE: 000/000
  - L1: 001/000
  - L2: 011/000
  - L3: 111/000
  - R1: 000/100
  - R2: 000/110
  - R3: 000/111
  - LR3: 111/111
- Transitions at tick:
  - IDLE: haz_req -> LR3; else left -> L1; else right -> R1; else IDLE.
  - L1 -> L2 -> L3 -> IDLE, unless haz_req at the tick, in which case -> LR3 immediately.
  - R1 -> R2 -> R3 -> IDLE, same hazard override.
  - LR3 -> IDLE always. Hazard therefore flashes all-on/all-off with period 2*STEP_DIV cycles.
- A turn sequence, once started, runs to L3/R3 even if its request drops; it always passes through IDLE before a new sequence.
- left->right switch mid-sequence: the left sequence completes, then IDLE for one step, then R1 at the following tick if right is still held.
- Output timing:
  - Outputs are registered decodes of the next state, so Lcba/Rabc/busy change on the same edge as the state.
  - Latency from a request asserted to the first lamp is 1..STEP_DIV cycles, depending on counter phase.
- Requests asserted and released entirely between ticks are ignored (not latched).
- Outputs are never X after reset. The patterns 001/011/111 and 100/110/111 are the only non-zero values per side.

Test Plan:
- Reset, then hold reset with left=1 for 10 cycles -> Lcba=000, Rabc=000, busy=0 throughout. On release with STEP_DIV=4, the first tick is the 4th edge -> Lcba=001.
- STEP_DIV=1, left=1 held -> Lcba repeats 001,011,111,000 on consecutive cycles, Rabc=000, busy=1,1,1,0.
- STEP_DIV=1, right pulse for one tick then 0 -> Rabc 100,110,111,000, then stays 000.
- STEP_DIV=1, left=1; assert hazard while in L2 -> next cycle 111/111, then 000/000, then 111/111 while hazard held.
- STEP_DIV=1, left=right=1 from IDLE -> 111/111 alternating with 000/000 (treated as hazard, no L1/R1).
- STEP_DIV=4, assert reset in R2 -> next edge 000/000, busy=0, counter=0; first tick after release is 4 cycles later.
